// File: rtl/pcie_apb_master.sv
// APB initiator for the PCIe DMA path: turns 32/64-bit register requests into
// one or two 32-bit APB transfers and returns data/error on a response channel.

package types_amba_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_in_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;
endpackage

// state  | meaning
// IDLE   | ready for a request
// SETUP  | APB setup phase of the current beat
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | response presented, waiting for consumer
module pcie_apb_master
  import types_amba_pkg::*;
#(
  parameter int timeout_cycles = 1023
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic        i_req_size,
  input  logic [31:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wstrb,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_err,
  output apb_in_type  o_apbo,
  input  apb_out_type i_apbi,
  output logic        o_busy
);

  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam int TO_LAST = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        beat_q, beat_d;
  logic        last_q, last_d;
  logic        write_q, write_d;
  logic        size_q, size_d;
  logic [29:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  apb_in_type  apb_q, apb_d;
  logic        half_q, half_d;
  logic        unused_addr;

  assign unused_addr = ^i_req_addr[1:0];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= IDLE;
      beat_q       <= 1'b0;
      last_q       <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      apb_q        <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_q       <= last_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      apb_q        <= apb_d;
    end
  end

  // Word half of the current beat: beat index for 64-bit, addr[2] for 32-bit.
  assign half_q = size_q ? beat_q : addr_q[0];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (i_req_valid && req_ready_q) begin
          write_d = i_req_write;
          size_d  = i_req_size;
          addr_d  = i_req_addr[31:2];
          wdata_d = i_req_wdata;
          wstrb_d = i_req_wstrb;
          rdata_d = '0;
          err_d   = 1'b0;
          beat_d  = 1'b0;
          last_d  = ~i_req_size;
          cnt_d   = '0;
          if (i_req_size && i_req_addr[2]) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (i_apbi.pready) begin
          if (!write_q) begin
            if (half_q) rdata_d[63:32] = i_apbi.prdata;
            else        rdata_d[31:0]  = i_apbi.prdata;
          end
          if (i_apbi.pslverr) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!last_q) begin
            beat_d  = 1'b1;
            last_d  = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = RESP;
          end
        end else if (timeout_cycles != 0 && cnt_q == CW'(TO_LAST)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // APB outputs are registered, so they are computed from the next state.
  assign half_d = size_d ? beat_d : addr_d[0];

  always_comb begin
    apb_d         = apb_q;
    apb_d.pprot   = 3'b000;
    apb_d.pselx   = (state_d == SETUP) || (state_d == ACCESS);
    apb_d.penable = (state_d == ACCESS);
    if (state_d == SETUP) begin
      apb_d.paddr  = size_d ? {addr_d[29:1], beat_d, 2'b00} : {addr_d, 2'b00};
      apb_d.pwrite = write_d;
      apb_d.pwdata = half_d ? wdata_d[63:32] : wdata_d[31:0];
      apb_d.pstrb  = half_d ? wstrb_d[7:4] : wstrb_d[3:0];
    end
  end

  assign req_ready_d  = (state_d == IDLE);
  assign resp_valid_d = (state_d == RESP);

  assign o_req_ready  = req_ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;
  assign o_apbo       = apb_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pcie_apb_master.sv
// Self-checking bench for pcie_apb_master: directed cases plus randomized
// requests compared against a transaction-level model of the expected APB traffic.
module tb_pcie_apb_master;
  import types_amba_pkg::*;

  localparam int T = 16;

  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  prot;
  } xfer_t;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic        i_req_size = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [63:0] i_req_wdata = '0;
  logic [7:0]  i_req_wstrb = '0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  logic [63:0] o_resp_rdata;
  logic        o_resp_err;
  apb_in_type  apbo;
  apb_out_type apbi;
  logic        o_busy;

  pcie_apb_master #(.timeout_cycles(T)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_size(i_req_size),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_apbo(apbo), .i_apbi(apbi), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass = 0;

  // slave configuration and observation
  int          cfg_waits = 0;
  int          cfg_err_idx = -1;
  logic [31:0] cfg_rd0 = '0;
  logic [31:0] cfg_rd1 = '0;
  int          pen_cycles = 0;
  xfer_t       xfers[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Slave: responds with pready after cfg_waits wait states of each access.
  initial begin
    int acc_n;
    int k;
    acc_n = 0;
    apbi = '0;
    forever begin
      @(negedge i_clk);
      if (apbo.pselx && apbo.penable) begin
        pen_cycles++;
        if (acc_n == cfg_waits) begin
          k = xfers.size();
          apbi.pready  = 1'b1;
          apbi.prdata  = (k == 0) ? cfg_rd0 : cfg_rd1;
          apbi.pslverr = (k == cfg_err_idx);
          xfers.push_back('{apbo.paddr, apbo.pwrite, apbo.pwdata, apbo.pstrb, apbo.pprot});
        end else begin
          apbi = '0;
        end
        acc_n++;
      end else begin
        acc_n = 0;
        apbi = '0;
      end
    end
  end

  task automatic do_txn(input string nm, input logic wr, input logic sz, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] ws, input int waits,
                        input int err_idx, input logic [31:0] rd0, input logic [31:0] rd1,
                        input int hold);
    xfer_t       exp_q[$];
    logic [63:0] exp_rd;
    logic        exp_err;
    int          exp_lat, exp_pen, nb, h, lat, guard;
    logic [31:0] a, rw;
    logic        saw_ready;

    // reference model: transfers, data placement, latency
    exp_rd = '0; exp_err = 1'b0; exp_lat = 1; exp_pen = 0;
    if (sz && addr[2]) begin
      exp_err = 1'b1;
    end else begin
      nb = sz ? 2 : 1;
      for (int i = 0; i < nb; i++) begin
        h  = sz ? i : int'(addr[2]);
        a  = sz ? ((addr & ~32'h7) + 32'(4 * i)) : (addr & ~32'h3);
        rw = (i == 0) ? rd0 : rd1;
        if (waits >= T) begin
          exp_err = 1'b1; exp_lat += 1 + T; exp_pen += T;
          break;
        end
        exp_q.push_back('{a, wr, wd[32*h +: 32], ws[4*h +: 4], 3'b000});
        exp_lat += 2 + waits;
        exp_pen += waits + 1;
        if (!wr) exp_rd[32*h +: 32] = rw;
        if (i == err_idx) begin
          exp_err = 1'b1;
          break;
        end
      end
    end

    cfg_waits = waits; cfg_err_idx = err_idx; cfg_rd0 = rd0; cfg_rd1 = rd1;
    xfers.delete(); pen_cycles = 0;

    guard = 0;
    while (!o_req_ready && guard < 50) begin @(negedge i_clk); guard++; end
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_write = wr; i_req_size = sz;
    i_req_addr = addr; i_req_wdata = wd; i_req_wstrb = ws;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    lat = 1; saw_ready = 1'b0;
    while (!o_resp_valid && lat < 200) begin
      if (o_req_ready) saw_ready = 1'b1;
      @(posedge i_clk); #1; lat++;
    end
    chk({nm, ".lat"}, 96'(lat), 96'(exp_lat));
    chk({nm, ".rdy_low"}, 96'(saw_ready | o_req_ready), 96'(0));
    chk({nm, ".err"}, 96'(o_resp_err), 96'(exp_err));
    chk({nm, ".rdata"}, 96'(o_resp_rdata), 96'(exp_rd));
    for (int c = 0; c < hold; c++) begin
      @(posedge i_clk); #1;
      chk({nm, ".hold"}, {o_resp_valid, o_req_ready, o_resp_err, o_resp_rdata},
          {1'b1, 1'b0, exp_err, exp_rd});
    end
    i_resp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_resp_ready = 1'b0;
    chk({nm, ".done"}, {o_req_ready, o_resp_valid}, {1'b1, 1'b0});
    chk({nm, ".pen"}, 96'(pen_cycles), 96'(exp_pen));
    chk({nm, ".nxfer"}, 96'(xfers.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < xfers.size(); i++)
      chk({nm, ".xfer"}, 96'(xfers[i]), 96'(exp_q[i]));
  endtask

  initial begin
    int guard;
    logic wr, sz;
    int waits, e, err_idx;
    logic [31:0] addr;

    #12;
    chk("rst.outs", {o_req_ready, o_resp_valid, apbo.pselx, apbo.penable, o_busy, o_resp_err},
        '0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(posedge i_clk); #1;
    chk("rst.ready", 96'(o_req_ready), 96'(1));

    do_txn("rd32", 1'b0, 1'b0, 32'h0000_1004, '0, '0, 0, -1, 32'hA5A5_0001, 32'h0, 0);
    do_txn("wr64", 1'b1, 1'b1, 32'h0000_2000, 64'h1122_3344_5566_7788, 8'hF0, 2, -1,
           32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
    do_txn("slverr", 1'b0, 1'b1, 32'h0000_2008, '0, '0, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_txn("timeout", 1'b0, 1'b0, 32'h0000_0010, '0, '0, 1000, -1, 32'h5555_AAAA, 32'h0, 0);
    do_txn("thresh", 1'b0, 1'b0, 32'h0000_0020, '0, '0, T - 1, -1, 32'h0BAD_CAFE, 32'h0, 0);
    do_txn("misalign", 1'b0, 1'b1, 32'h0000_3004, '0, '0, 0, -1, 32'h1, 32'h2, 5);
    do_txn("wstrb0", 1'b1, 1'b0, 32'h0000_4006, 64'hFEDC_BA98_7654_3210, 8'h00, 1, -1,
           32'h7777_7777, 32'h0, 0);

    // reset during beat 1 access
    cfg_waits = 3; cfg_err_idx = -1; cfg_rd0 = 32'h1111_1111; cfg_rd1 = 32'h2222_2222;
    xfers.delete();
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_size = 1'b1; i_req_addr = 32'h0000_5000;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    guard = 0;
    while (!(xfers.size() == 1 && apbo.penable) && guard < 100) begin
      @(negedge i_clk); guard++;
    end
    chk("rstmid.reach", 96'(guard < 100), 96'(1));
    #2;
    i_nrst = 1'b0;
    #1;
    chk("rstmid.apb", {apbo.pselx, apbo.penable, o_resp_valid, o_busy, o_req_ready}, '0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("rstmid.noresp", 96'(o_resp_valid), 96'(0));
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(posedge i_clk); #1;
    chk("rstmid.ready", {o_req_ready, o_resp_valid}, {1'b1, 1'b0});
    do_txn("postrst", 1'b0, 1'b0, 32'h0000_6000, '0, '0, 0, -1, 32'hC0DE_0042, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom_range(0, 1));
      sz    = 1'($urandom_range(0, 1));
      addr  = $urandom();
      waits = ($urandom_range(0, 19) == 0) ? T : int'($urandom_range(0, 3));
      e     = int'($urandom_range(0, 7));
      err_idx = (e < 2) ? e : -1;
      do_txn("rand", wr, sz, addr, {$urandom(), $urandom()}, 8'($urandom()), waits, err_idx,
             $urandom(), $urandom(), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
